dma_priority_arbiter: RTL and testbench
=======================================

# dma_priority_arbiter

Channel request resolver for the 8237A-style DMA controller. It samples the four DREQ inputs and the software request register, applies the per-channel masks, and picks one channel by fixed or rotating priority. It then drives ReqID/ValidReqID to the timing/control FSM and holds that grant, with the matching DACK, until the service completes. It also holds the rotating-priority state and the request bits that feed the status register's upper nibble.

## Interface
- NCH, 4: number of channels; fixed at 4, since ReqID is 2 bits.
- Clock  in  1  system clock; all state updates on its rising edge.
- nReset  in  1  asynchronous, active-low reset.
- DREQ  in  4  external DMA requests; polarity set by DreqSenseLow.
- MaskReg  in  4  per-channel masks; 1 = channel blocked.
- CmdDisable  in  1  command register bit 2; 1 = no new grants.
- CmdRotate  in  1  command register bit 4; 1 = rotating priority.
- DreqSenseLow  in  1  command register bit 6; 1 = DREQ is active-low.
- DackSenseHigh  in  1  command register bit 7; 1 = DACK is active-high.
- Hlda  in  1  hold acknowledge from the CPU.
- ServiceDone  in  1  one-cycle pulse from the timing FSM at end of service (EOP, or return to idle).
- RequestRegLoad  in  1  software write to the request register.
- DB  in  3  request write data: bit 2 = set(1)/clear(0), bits 1:0 = channel.
- MasterClear  in  1  software master clear.
- ReqID  out  2  granted channel.
- ValidReqID  out  1  a grant is pending or active.
- DACK  out  4  DMA acknowledge, one-hot when active.
- ReqStatus  out  4  sampled effective requests, for status register bits 7:4.

## Operation
- **Effective request.** Per channel c: eff[c] = (registered DREQ[c] XOR DreqSenseLow) OR SwReq[c].
  - Software requests ignore MaskReg.
  - Arbitration candidates are eff[c] AND NOT (MaskReg[c] AND NOT SwReq[c]).
- **Software request register SwReq[3:0].**
  - RequestRegLoad sets or clears SwReq[DB[1:0]] according to DB[2].
  - SwReq[c] clears on ServiceDone for channel c and on MasterClear.
- **Priority.**
  - Fixed priority: channel 0 highest, channel 3 lowest.
  - Rotating priority: a 2-bit pointer Low names the lowest-priority channel; search order is Low+1, Low+2, Low+3, Low (mod 4).
  - On ServiceDone of channel c in rotating mode, Low <= c.
- **State machine.** States: IDLE, GRANT, ACTIVE, RELEASE.
  - IDLE → GRANT when any candidate exists and CmdDisable = 0. ReqID latches the winner.
  - GRANT → ACTIVE when Hlda = 1.
  - GRANT → IDLE when Hlda = 0 and the latched channel is no longer a candidate.
  - ACTIVE → RELEASE on ServiceDone.
  - ACTIVE → IDLE when Hlda falls without ServiceDone; the pointer is not updated.
  - RELEASE → IDLE unconditionally. The pointer and SwReq update here.
- **Outputs by state.**
  - ValidReqID = 1 in GRANT and ACTIVE.
  - DACK[ReqID] is active only in ACTIVE; all other DACK bits inactive.
  - Active level is DackSenseHigh; inactive level is its complement.
- **Grant stability.** DREQ, mask and priority changes during GRANT or ACTIVE never change ReqID. CmdDisable during ACTIVE does not abort the service in progress.
- **MasterClear.**
  - Takes effect on the next edge: state to IDLE, Low = 3 (so channel 0 is highest), SwReq = 0.
  - Takes precedence over all other events in the same cycle.
- **Simultaneous RequestRegLoad and ServiceDone on the same channel:** the load wins.

## Timing
- Reset values:
  - state = IDLE, ReqID = 0, ValidReqID = 0, ReqStatus = 0, SwReq = 0, Low = 3.
  - DACK = 4'b0000. While DackSenseHigh = 0, the combinational inactive level 4'b1111 applies.
- Request latency:
  - DREQ is registered at edge k.
  - The IDLE→GRANT transition happens at edge k+1, so ValidReqID is high after edge k+1.
  - Minimum from DREQ to ValidReqID: 2 clocks.
- DACK asserts in the cycle after Hlda is sampled high; it drops in the cycle after ServiceDone is sampled.
- RELEASE lasts exactly 1 cycle, so the earliest re-grant is 2 cycles after ServiceDone.
- ReqStatus is registered with the DREQ sample, so it trails DREQ by 1 cycle.

## Configuration
- DMA_ROTATING_PRIORITY_EN
  - Defined: CmdRotate selects between rotating and fixed priority, and the Low register is present.
  - Undefined: fixed priority only, CmdRotate is ignored, and Low is removed.

## Test plan
- **Fixed priority.** CmdRotate = 0, DREQ = 4'b1010. → ReqID = 1 and ValidReqID after 2 clocks. With Hlda = 1: DACK = 4'b0010. After ServiceDone with DREQ still 4'b1010: next grant ReqID = 1 again.
- **Rotating priority.** CmdRotate = 1, DREQ = 4'b1111. → Grant order across four ServiceDone pulses is 0, 1, 2, 3, then 0.
- **Mask and software request.** MaskReg = 4'b0100, DREQ[2] = 1. → No grant. Then RequestRegLoad with DB = 3'b110 → ReqID = 2 granted; SwReq[2] = 0 after ServiceDone.
- **Request withdrawn and Hlda loss.**
  - DREQ[3] pulses high and falls while in GRANT with Hlda = 0 → return to IDLE with ValidReqID = 0 and no DACK.
  - Hlda falls in ACTIVE → IDLE with the pointer unchanged.
- **Polarity and clear.** DreqSenseLow = 1, DackSenseHigh = 0, DREQ = 4'b1110. → Channel 0 granted and DACK = 4'b1110. MasterClear during ACTIVE → IDLE next cycle and DACK = 4'b1111.
- **Reset mid-service.** nReset asserted in ACTIVE → ValidReqID = 0 and DACK = 0 immediately (asynchronous); after release, a re-arbitration starting with fixed order 0 first.

Source files
------------

// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bundle between the DMA arbiter and its surrounding controller.
interface dma_priority_arbiter_if;
    logic [3:0] dreq;
    logic [3:0] mask_reg;
    logic       cmd_disable;
    logic       cmd_rotate;
    logic       dreq_sense_low;
    logic       dack_sense_high;
    logic       hlda;
    logic       service_done;
    logic       request_reg_load;
    logic [2:0] db;
    logic       master_clear;
    logic [1:0] req_id;
    logic       valid_req_id;
    logic [3:0] dack;
    logic [3:0] req_status;

    modport slave (
        input  dreq, mask_reg, cmd_disable, cmd_rotate, dreq_sense_low, dack_sense_high,
        input  hlda, service_done, request_reg_load, db, master_clear,
        output req_id, valid_req_id, dack, req_status
    );

    modport master (
        output dreq, mask_reg, cmd_disable, cmd_rotate, dreq_sense_low, dack_sense_high,
        output hlda, service_done, request_reg_load, db, master_clear,
        input  req_id, valid_req_id, dack, req_status
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 8237A-style channel request resolver: fixed/rotating priority, grant hold and DACK generation.
// Rotating priority and the Low pointer exist only when DMA_ROTATING_PRIORITY_EN is defined.
module dma_priority_arbiter (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    dma_priority_arbiter_if.slave  bus
);

    localparam int unsigned NumCh = 4;

    typedef enum logic [1:0] {StIdle, StGrant, StActive, StRelease} state_e;

    state_e           state_q, state_d;
    logic [1:0]       req_id_q, req_id_d;
    logic [NumCh-1:0] dreq_q;
    logic [NumCh-1:0] req_status_q, req_status_d;
    logic [NumCh-1:0] sw_req_q, sw_req_d;
    logic [NumCh-1:0] eff_req, cand;
    logic [NumCh-1:0] dack_act;
    logic [1:0]       low_eff;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             found;
    logic             svc_done;

    assign svc_done = (state_q == StActive) && bus.service_done;

    // Software requests bypass the mask.
    always_comb begin
        eff_req = (dreq_q ^ {NumCh{bus.dreq_sense_low}}) | sw_req_q;
        cand    = eff_req & ~(bus.mask_reg & ~sw_req_q);
    end

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [1:0] low_q, low_d;

    assign low_eff = bus.cmd_rotate ? low_q : 2'd3;

    always_comb begin
        low_d = low_q;
        if (svc_done && bus.cmd_rotate) begin
            low_d = req_id_q;
        end
        if (bus.master_clear) begin
            low_d = 2'd3;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            low_q <= 2'd3;
        end else begin
            low_q <= low_d;
        end
    end
`else
    logic unused_cmd_rotate;

    assign unused_cmd_rotate = bus.cmd_rotate;
    assign low_eff           = 2'd3;
`endif

    // Search starts just above the lowest-priority channel; Low = 3 gives fixed order.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int unsigned i = 1; i <= NumCh; i++) begin
            idx = low_eff + 2'(i);
            if (!found && cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // SwReq clears on the edge that enters RELEASE; a same-cycle load wins.
    always_comb begin
        sw_req_d = sw_req_q;
        if (svc_done) begin
            sw_req_d[req_id_q] = 1'b0;
        end
        if (bus.request_reg_load) begin
            sw_req_d[bus.db[1:0]] = bus.db[2];
        end
        if (bus.master_clear) begin
            sw_req_d = '0;
        end
    end

    assign req_status_d = (bus.dreq ^ {NumCh{bus.dreq_sense_low}}) | sw_req_d;

    always_comb begin
        state_d  = state_q;
        req_id_d = req_id_q;
        unique case (state_q)
            StIdle: begin
                if ((|cand) && !bus.cmd_disable) begin
                    state_d  = StGrant;
                    req_id_d = winner;
                end
            end
            StGrant: begin
                if (bus.hlda) begin
                    state_d = StActive;
                end else if (!cand[req_id_q]) begin
                    state_d = StIdle;
                end
            end
            StActive: begin
                if (bus.service_done) begin
                    state_d = StRelease;
                end else if (!bus.hlda) begin
                    state_d = StIdle;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (bus.master_clear) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            req_id_q     <= 2'd0;
            dreq_q       <= '0;
            req_status_q <= '0;
            sw_req_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_id_q     <= req_id_d;
            dreq_q       <= bus.dreq;
            req_status_q <= req_status_d;
            sw_req_q     <= sw_req_d;
        end
    end

    always_comb begin
        dack_act = '0;
        if (state_q == StActive) begin
            dack_act[req_id_q] = 1'b1;
        end
        bus.dack         = bus.dack_sense_high ? dack_act : ~dack_act;
        bus.valid_req_id = (state_q == StGrant) || (state_q == StActive);
        bus.req_id       = req_id_q;
        bus.req_status   = req_status_q;
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter; rotating expectations follow DMA_ROTATING_PRIORITY_EN.
module tb_dma_priority_arbiter;

`ifdef DMA_ROTATING_PRIORITY_EN
    localparam bit RotEn = 1'b1;
`else
    localparam bit RotEn = 1'b0;
`endif

    logic clk_i;
    logic rst_ni;
    int   n_cmp;
    int   n_err;
    int   exp_id;

    dma_priority_arbiter_if bus ();

    dma_priority_arbiter u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // From ACTIVE: pulse ServiceDone, then let RELEASE pass.
    task automatic finish_service();
        bus.service_done = 1'b1;
        tick(1);
        bus.service_done = 1'b0;
        tick(1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_ni               = 1'b0;
        bus.dreq             = 4'b0000;
        bus.mask_reg         = 4'b0000;
        bus.cmd_disable      = 1'b0;
        bus.cmd_rotate       = 1'b0;
        bus.dreq_sense_low   = 1'b0;
        bus.dack_sense_high  = 1'b1;
        bus.hlda             = 1'b0;
        bus.service_done     = 1'b0;
        bus.request_reg_load = 1'b0;
        bus.db               = 3'b000;
        bus.master_clear     = 1'b0;
        tick(2);
        check_eq("reset_valid", 32'(bus.valid_req_id), 32'd0);
        check_eq("reset_reqid", 32'(bus.req_id), 32'd0);
        check_eq("reset_dack", 32'(bus.dack), 32'h0);
        check_eq("reset_status", 32'(bus.req_status), 32'h0);
        #2 rst_ni = 1'b1;
        tick(1);

        // Fixed priority, DREQ = 1010
        bus.dreq = 4'b1010;
        tick(1);
        check_eq("fix_status", 32'(bus.req_status), 32'hA);
        check_eq("fix_not_yet", 32'(bus.valid_req_id), 32'd0);
        tick(1);
        check_eq("fix_valid", 32'(bus.valid_req_id), 32'd1);
        check_eq("fix_reqid", 32'(bus.req_id), 32'd1);
        check_eq("fix_grant_nodack", 32'(bus.dack), 32'h0);
        bus.hlda = 1'b1;
        tick(1);
        check_eq("fix_dack", 32'(bus.dack), 32'h2);
        bus.service_done = 1'b1;
        tick(1);
        bus.service_done = 1'b0;
        check_eq("fix_rel_dack", 32'(bus.dack), 32'h0);
        check_eq("fix_rel_valid", 32'(bus.valid_req_id), 32'd0);
        tick(1);
        check_eq("fix_idle_valid", 32'(bus.valid_req_id), 32'd0);
        tick(1);
        check_eq("fix_regrant_valid", 32'(bus.valid_req_id), 32'd1);
        check_eq("fix_regrant_id", 32'(bus.req_id), 32'd1);
        tick(1);
        bus.dreq = 4'b0000;
        finish_service();
        bus.hlda = 1'b0;
        tick(1);

        // Rotating priority, all channels requesting
        bus.cmd_rotate = 1'b1;
        bus.dreq       = 4'b1111;
        bus.hlda       = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            exp_id = RotEn ? (i % 4) : 0;
            check_eq($sformatf("rot_id%0d", i), 32'(bus.req_id), 32'(exp_id));
            tick(1);
            check_eq($sformatf("rot_dack%0d", i), 32'(bus.dack), 32'(1 << exp_id));
            if (i == 4) bus.dreq = 4'b0000;
            finish_service();
            if (i < 4) tick(1);
        end
        tick(1);

        // Hlda lost in ACTIVE: pointer must not advance
        exp_id   = RotEn ? 1 : 0;
        bus.dreq = 4'b1111;
        tick(2);
        check_eq("hl_id", 32'(bus.req_id), 32'(exp_id));
        tick(1);
        check_eq("hl_dack", 32'(bus.dack), 32'(1 << exp_id));
        bus.hlda = 1'b0;
        tick(1);
        check_eq("hl_idle_valid", 32'(bus.valid_req_id), 32'd0);
        check_eq("hl_idle_dack", 32'(bus.dack), 32'h0);
        tick(1);
        check_eq("hl_regrant_id", 32'(bus.req_id), 32'(exp_id));
        check_eq("hl_regrant_valid", 32'(bus.valid_req_id), 32'd1);
        bus.hlda = 1'b1;
        tick(1);
        bus.dreq = 4'b0000;
        finish_service();
        bus.hlda       = 1'b0;
        bus.cmd_rotate = 1'b0;
        tick(1);

        // Request withdrawn during GRANT
        bus.dreq = 4'b1000;
        tick(2);
        check_eq("wd_valid", 32'(bus.valid_req_id), 32'd1);
        check_eq("wd_id", 32'(bus.req_id), 32'd3);
        bus.dreq = 4'b0000;
        tick(1);
        check_eq("wd_hold", 32'(bus.valid_req_id), 32'd1);
        tick(1);
        check_eq("wd_drop", 32'(bus.valid_req_id), 32'd0);
        check_eq("wd_dack", 32'(bus.dack), 32'h0);

        // Mask blocks DREQ; software request bypasses it
        bus.mask_reg = 4'b0100;
        bus.dreq     = 4'b0100;
        tick(3);
        check_eq("mask_block", 32'(bus.valid_req_id), 32'd0);
        bus.request_reg_load = 1'b1;
        bus.db               = 3'b110;
        tick(1);
        bus.request_reg_load = 1'b0;
        tick(1);
        check_eq("sw_valid", 32'(bus.valid_req_id), 32'd1);
        check_eq("sw_id", 32'(bus.req_id), 32'd2);
        bus.hlda = 1'b1;
        tick(1);
        check_eq("sw_dack", 32'(bus.dack), 32'h4);
        bus.service_done     = 1'b1;
        bus.request_reg_load = 1'b1;
        tick(1);
        bus.service_done     = 1'b0;
        bus.request_reg_load = 1'b0;
        tick(2);
        check_eq("load_wins_valid", 32'(bus.valid_req_id), 32'd1);
        check_eq("load_wins_id", 32'(bus.req_id), 32'd2);
        tick(1);
        finish_service();
        tick(2);
        check_eq("sw_cleared", 32'(bus.valid_req_id), 32'd0);
        bus.mask_reg = 4'b0000;
        bus.dreq     = 4'b0000;
        bus.hlda     = 1'b0;
        tick(2);

        // Inverted polarities and MasterClear
        bus.dreq_sense_low  = 1'b1;
        bus.dack_sense_high = 1'b0;
        bus.dreq            = 4'b1110;
        #1;
        check_eq("pol_idle_dack", 32'(bus.dack), 32'hF);
        tick(2);
        check_eq("pol_id", 32'(bus.req_id), 32'd0);
        check_eq("pol_valid", 32'(bus.valid_req_id), 32'd1);
        bus.hlda = 1'b1;
        tick(1);
        check_eq("pol_dack", 32'(bus.dack), 32'hE);
        bus.master_clear = 1'b1;
        bus.dreq         = 4'b1111;
        tick(1);
        bus.master_clear = 1'b0;
        check_eq("mc_valid", 32'(bus.valid_req_id), 32'd0);
        check_eq("mc_dack", 32'(bus.dack), 32'hF);
        tick(1);
        check_eq("mc_stay_idle", 32'(bus.valid_req_id), 32'd0);

        // Reset in the middle of a service
        bus.dreq_sense_low  = 1'b0;
        bus.dack_sense_high = 1'b1;
        bus.cmd_rotate      = 1'b1;
        tick(1);
        check_eq("rs_first_id", 32'(bus.req_id), 32'd0);
        tick(1);
        finish_service();
        tick(1);
        exp_id = RotEn ? 1 : 0;
        check_eq("rs_second_id", 32'(bus.req_id), 32'(exp_id));
        tick(1);
        check_eq("rs_active_dack", 32'(bus.dack), 32'(1 << exp_id));
        #2 rst_ni = 1'b0;
        #1;
        check_eq("rs_async_valid", 32'(bus.valid_req_id), 32'd0);
        check_eq("rs_async_dack", 32'(bus.dack), 32'h0);
        #2 rst_ni = 1'b1;
        tick(2);
        check_eq("rs_rearb_valid", 32'(bus.valid_req_id), 32'd1);
        check_eq("rs_rearb_id", 32'(bus.req_id), 32'd0);
        bus.dreq = 4'b0000;
        bus.hlda = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
